// File: rtl/fan_controller_pkg.sv
// Shared defaults and helpers for the fan controller and its per-channel tach logic.
package fan_controller_pkg;
  localparam int DEF_CLK_FREQ = 12_000_000;
  localparam int DEF_PWM_FREQ = 25_000;

  // Counter width that stays at least 1 bit for tiny ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/fan_tach_chan.sv
// One fan channel's tach path: synchroniser, debounce, rising-edge window counter, stall tracking.
module fan_tach_chan
  import fan_controller_pkg::*;
#(
  parameter int TACH_W      = 16,
  parameter int DEBOUNCE    = 4,
  parameter int STALL_GATES = 2
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              tach_i,
  input  logic              gate_end,
  input  logic              armed,
  input  logic              clr,
  output logic [TACH_W-1:0] rev_count,
  output logic              stall
);
  localparam int DBW = clog2_min1(DEBOUNCE);
  localparam int SW  = clog2_min1(STALL_GATES + 1);

  logic [1:0]        sync;
  logic              filt;
  logic [DBW-1:0]    db_cnt;
  logic              flip, rise;
  logic [TACH_W-1:0] win, win_inc;
  logic [SW-1:0]     zcnt;

  // db_cnt counts consecutive synced samples that disagree with the filtered level.
  assign flip    = (sync[1] != filt) && (db_cnt == DBW'(DEBOUNCE - 1));
  assign rise    = flip && sync[1];
  assign win_inc = (rise && !(&win)) ? win + 1'b1 : win;
  assign stall   = (zcnt == SW'(STALL_GATES));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '0;
      filt      <= 1'b0;
      db_cnt    <= '0;
      win       <= '0;
      rev_count <= '0;
      zcnt      <= '0;
    end else begin
      sync <= {sync[0], tach_i};
      if (sync[1] == filt || flip) db_cnt <= '0;
      else                         db_cnt <= db_cnt + 1'b1;
      if (flip) filt <= sync[1];

      // Edge landing on the terminal clock belongs to the closing window.
      if (gate_end) begin
        rev_count <= win_inc;
        win       <= '0;
      end else begin
        win <= win_inc;
      end

      if (clr)
        zcnt <= '0;
      else if (gate_end) begin
        if (win_inc != '0 || !armed) zcnt <= '0;
        else if (!stall)             zcnt <= zcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fan_controller.sv
// N-channel fan controller: shared PWM period and tach gate counters, per-channel PWM and tach.
module fan_controller
  import fan_controller_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int PWM_FREQ    = DEF_PWM_FREQ,
  parameter int DUTY_W      = 8,
  parameter int TACH_W      = 16,
  parameter int GATE_CYCLES = CLK_FREQ,
  parameter int DEBOUNCE    = 4,
  parameter int STALL_GATES = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        enable,
  input  logic [N_CH*DUTY_W-1:0] duty,
  input  logic [N_CH-1:0]        tach_i,
  output logic [N_CH-1:0]        pwm_o,
  output logic [N_CH*TACH_W-1:0] rev_count,
  output logic                   count_valid,
  output logic [N_CH-1:0]        stall
);
  localparam int P  = CLK_FREQ / PWM_FREQ;
  localparam int PW = clog2_min1(P);
  localparam int GW = clog2_min1(GATE_CYCLES);
  localparam int MW = DUTY_W + PW;

  logic [PW-1:0]                 pcnt;
  logic [GW-1:0]                 gcnt;
  logic                          period_start, gate_end;
  logic [N_CH-1:0]               en_lat;
  logic [N_CH-1:0][DUTY_W-1:0]   duty_v, duty_lat;
  logic [N_CH-1:0]               pwm_nxt;

  assign duty_v       = duty;
  assign period_start = (pcnt == '0);
  assign gate_end     = (gcnt == GW'(GATE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt        <= '0;
      gcnt        <= '0;
      count_valid <= 1'b0;
      en_lat      <= '0;
      duty_lat    <= '0;
      pwm_o       <= '0;
    end else begin
      pcnt        <= (pcnt == PW'(P - 1)) ? '0 : pcnt + 1'b1;
      gcnt        <= gate_end ? '0 : gcnt + 1'b1;
      count_valid <= gate_end;
      pwm_o       <= pwm_nxt;
      if (period_start) begin
        en_lat   <= enable;
        duty_lat <= duty_v;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic              en_eff;
    logic [DUTY_W-1:0] d_eff;
    logic [MW-1:0]     on_cyc;

    // On the period's first clock the live inputs are what is being latched.
    assign en_eff     = period_start ? enable[k] : en_lat[k];
    assign d_eff      = period_start ? duty_v[k] : duty_lat[k];
    assign on_cyc     = (MW'(d_eff) * MW'(P)) >> DUTY_W;
    assign pwm_nxt[k] = en_eff && (d_eff != '0) && ((&d_eff) || (MW'(pcnt) < on_cyc));

    fan_tach_chan #(
      .TACH_W      (TACH_W),
      .DEBOUNCE    (DEBOUNCE),
      .STALL_GATES (STALL_GATES)
    ) u_tach (
      .clk       (clk),
      .reset     (reset),
      .tach_i    (tach_i[k]),
      .gate_end  (gate_end),
      .armed     (en_lat[k] && (duty_lat[k] != '0)),
      .clr       (!enable[k] || (duty_v[k] == '0)),
      .rev_count (rev_count[k*TACH_W +: TACH_W]),
      .stall     (stall[k])
    );
  end
endmodule

// File: tb/tb_fan_controller.sv
// Bench for fan_controller: two instances (16-bit/120-clk gate and 4-bit/240-clk gate) vs a reference model.
module tb_fan_controller;
  localparam int P = 12, DB = 4, SG = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  enable = '0, tach = '0;
  logic [15:0] duty = '0;
  logic [1:0]  pwm_a, pwm_b, stall_a, stall_b;
  logic        cv_a, cv_b;
  logic [31:0] rev_a;
  logic [7:0]  rev_b;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  fan_controller #(.N_CH(2), .CLK_FREQ(12000), .PWM_FREQ(1000), .DUTY_W(8), .TACH_W(16),
                   .GATE_CYCLES(120), .DEBOUNCE(4), .STALL_GATES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty), .tach_i(tach),
    .pwm_o(pwm_a), .rev_count(rev_a), .count_valid(cv_a), .stall(stall_a));

  fan_controller #(.N_CH(2), .CLK_FREQ(12000), .PWM_FREQ(1000), .DUTY_W(8), .TACH_W(4),
                   .GATE_CYCLES(240), .DEBOUNCE(4), .STALL_GATES(2)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty), .tach_i(tach),
    .pwm_o(pwm_b), .rev_count(rev_b), .count_valid(cv_b), .stall(stall_b));

  // Reference model: tach history per channel, per-instance window tallies.
  int gl[2]  = '{120, 240};
  int sat[2] = '{65535, 15};
  int k;
  int hist[2][$];
  bit filt[2];
  int wc[2][2], erev[2][2], z[2][2];
  bit ecv[2], lat_en[2], epwm[2];
  int lat_d[2];

  // Tach stimulus: 0 idle, 1 periodic, 2 random holds, 3 scripted queue.
  int tmode[2] = '{0, 0}, tper[2] = '{16, 16}, thi[2] = '{8, 8}, tph[2] = '{0, 0}, thold[2] = '{0, 0};
  bit tscript[2][$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rise[2];
    bit ok, close, armed, clr;
    int s, m, ph;
    if (reset) begin
      k = 0;
      for (int c = 0; c < 2; c++) begin
        hist[c].delete(); hist[c].push_back(0);
        filt[c] = 0; lat_en[c] = 0; lat_d[c] = 0; epwm[c] = 0;
        for (int d = 0; d < 2; d++) begin wc[d][c] = 0; erev[d][c] = 0; z[d][c] = 0; end
      end
      ecv = '{0, 0};
      return;
    end
    k++;
    for (int c = 0; c < 2; c++) hist[c].push_back(int'(tach[c]));
    // Filtered level flips once the last DB synchronised samples all disagree with it.
    for (int c = 0; c < 2; c++) begin
      ok = 1;
      for (int j = 0; j < DB; j++) begin
        m = k - j;
        if (m < 1) ok = 0;
        else begin
          s = (m >= 2) ? hist[c][m-2] : 0;
          if (s == int'(filt[c])) ok = 0;
        end
      end
      rise[c] = ok && !filt[c];
      if (ok) filt[c] = !filt[c];
    end
    for (int d = 0; d < 2; d++) begin
      close  = (k % gl[d]) == 0;
      ecv[d] = close;
      for (int c = 0; c < 2; c++) begin
        wc[d][c] += int'(rise[c]);
        armed = lat_en[c] && lat_d[c] != 0;
        clr   = !enable[c] || duty[c*8 +: 8] == 0;
        if (clr) z[d][c] = 0;
        else if (close) z[d][c] = (wc[d][c] != 0 || !armed) ? 0 : ((z[d][c] < SG) ? z[d][c] + 1 : SG);
        if (close) begin
          erev[d][c] = (wc[d][c] > sat[d]) ? sat[d] : wc[d][c];
          wc[d][c] = 0;
        end
      end
    end
    ph = (k - 1) % P;
    for (int c = 0; c < 2; c++) begin
      if (ph == 0) begin lat_en[c] = enable[c]; lat_d[c] = int'(duty[c*8 +: 8]); end
      epwm[c] = lat_en[c] && lat_d[c] != 0 && (lat_d[c] == 255 || ph < ((lat_d[c] * P) >> 8));
    end
  endtask

  task automatic tach_gen();
    for (int c = 0; c < 2; c++) begin
      case (tmode[c])
        0: tach[c] = 1'b0;
        1: begin tach[c] = (tph[c] < thi[c]); tph[c] = (tph[c] + 1) % tper[c]; end
        2: begin
          if (thold[c] == 0) begin
            tach[c] = 1'($urandom_range(0, 1));
            thold[c] = $urandom_range(1, 7);
          end
          thold[c]--;
        end
        default: tach[c] = (tscript[c].size() > 0) ? tscript[c].pop_front() : 1'b0;
      endcase
    end
  endtask

  task automatic tick();
    tach_gen();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("pwm_a[%0d]", c), int'(pwm_a[c]), int'(epwm[c]));
      chk($sformatf("pwm_b[%0d]", c), int'(pwm_b[c]), int'(epwm[c]));
      chk($sformatf("rev_a[%0d]", c), int'(rev_a[c*16 +: 16]), erev[0][c]);
      chk($sformatf("rev_b[%0d]", c), int'(rev_b[c*4 +: 4]), erev[1][c]);
      chk($sformatf("stall_a[%0d]", c), int'(stall_a[c]), int'(z[0][c] == SG));
      chk($sformatf("stall_b[%0d]", c), int'(stall_b[c]), int'(z[1][c] == SG));
    end
    chk("cv_a", int'(cv_a), int'(ecv[0]));
    chk("cv_b", int'(cv_b), int'(ecv[1]));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cv(input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (!cv_a && n < lim);
    if (!cv_a) begin
      n_vec++; n_err++;
      $display("FAIL cv_timeout: got no count_valid within %0d clocks", lim);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic add_bits(input int c, input bit v, input int n);
    for (int i = 0; i < n; i++) tscript[c].push_back(v);
  endtask

  task automatic add_pulses(input int c, input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin add_bits(c, 1'b1, h); add_bits(c, 1'b0, l); end
  endtask

  typedef struct { bit en0; int d0; int d1; int on0; int on1; } pwm_vec_t;
  pwm_vec_t tbl[6];

  initial begin
    int n, h0, h1;
    tbl[0] = '{1, 128,  64,  6, 3};
    tbl[1] = '{1,   0, 255,  0, 12};
    tbl[2] = '{1, 255,   1, 12, 0};
    tbl[3] = '{0, 128, 200,  0, 9};
    tbl[4] = '{1, 254,  32, 11, 1};
    tbl[5] = '{1, 200, 128,  9, 6};

    reset = 1'b1; ticks(3);
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_rev", int'(rev_a), 0);
    chk("rst_cv", int'(cv_a), 0);
    chk("rst_stall", int'(stall_a), 0);
    reset = 1'b0;

    // PWM widths per period.
    foreach (tbl[i]) begin
      enable = {1'b1, tbl[i].en0};
      duty = {8'(tbl[i].d1), 8'(tbl[i].d0)};
      ticks(2 * P);
      h0 = 0; h1 = 0;
      for (int j = 0; j < P; j++) begin tick(); h0 += int'(pwm_a[0]); h1 += int'(pwm_a[1]); end
      chk($sformatf("tbl%0d_on0", i), h0, tbl[i].on0);
      chk($sformatf("tbl%0d_on1", i), h1, tbl[i].on1);
    end

    // Mid-period duty change applies from the next period.
    enable = 2'b11; duty = {8'd64, 8'd128};
    ticks(2 * P);
    n = 0;
    do begin tick(); n++; end while (!(pwm_a[0] && !pwm_b[1]) && n < 3 * P);
    while (pwm_a[0] && n < 4 * P) begin tick(); n++; end
    do begin tick(); n++; end while (!pwm_a[0] && n < 6 * P);
    chk("mid_sync", int'(pwm_a[0]), 1);
    ticks(3);
    duty[7:0] = 8'd255;
    h0 = 0;
    for (int j = 0; j < 8; j++) begin tick(); h0 += int'(pwm_a[0]); end
    chk("mid_old_tail", h0, 2);
    h0 = 0;
    for (int j = 0; j < P; j++) begin tick(); h0 += int'(pwm_a[0]); end
    chk("mid_new_full", h0, 12);

    // Clean pulses with glitches, per-channel rates.
    tmode = '{0, 0}; duty = {8'd64, 8'd128};
    do_reset();
    wait_cv(200, n);
    tmode = '{3, 3};
    add_pulses(0, 10, 5, 5);
    add_bits(0, 0, 6); add_bits(0, 1, 2); add_bits(0, 0, 6); add_bits(0, 1, 2); add_bits(0, 0, 4);
    add_pulses(1, 5, 6, 6);
    wait_cv(200, n);
    chk("glitch_rev0", int'(rev_a[15:0]), 10);
    chk("glitch_rev1", int'(rev_a[31:16]), 5);
    chk("glitch_cv_period", n, 120);
    chk("glitch_rev4_0", int'(rev_b[3:0]), 10);
    chk("glitch_rev4_1", int'(rev_b[7:4]), 5);

    // Saturation of the 4-bit counter.
    do_reset();
    add_pulses(0, 20, 5, 5);
    wait_cv(200, n);
    chk("sat_win1", int'(rev_a[15:0]), 12);
    wait_cv(200, n);
    chk("sat_win2", int'(rev_a[15:0]), 8);
    chk("sat_rev4", int'(rev_b[3:0]), 15);

    // Stall assertion, recovery and immediate clear.
    tmode = '{0, 0}; enable = 2'b11; duty = {8'd200, 8'd128};
    do_reset();
    wait_cv(200, n);
    chk("stall_win1", int'(stall_a), 0);
    wait_cv(200, n);
    chk("stall_win2", int'(stall_a), 3);
    tmode[0] = 1; tper[0] = 16; thi[0] = 8; tph[0] = 0;
    wait_cv(200, n);
    chk("stall_recover", int'(stall_a), 2);
    enable[1] = 1'b0;
    tick();
    chk("stall_en_clear", int'(stall_a), 0);

    // Reset mid-period and mid-window.
    enable = 2'b11;
    ticks(53);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_pwm", int'(pwm_a), 0);
    chk("rst_mid_rev", int'(rev_a), 0);
    chk("rst_mid_stall", int'(stall_a), 0);
    wait_cv(300, n);
    chk("rst_first_cv", n, 120);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        enable = 2'($urandom_range(0, 3));
        duty = 16'($urandom);
        if ($urandom_range(0, 3) == 0) duty[7:0] = 8'd0;
        if ($urandom_range(0, 3) == 0) duty[15:8] = 8'd255;
        for (int c = 0; c < 2; c++) begin
          tmode[c] = $urandom_range(0, 2);
          tper[c] = $urandom_range(6, 24);
          thi[c] = $urandom_range(1, tper[c] - 1);
          tph[c] = 0;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
